// File: rtl/if_stage_pkg.sv
// Shared types for the instruction-fetch stage: pre-IF and decode bus
// layouts plus queue sizing constants.
package if_stage_pkg;

  localparam int PF_TO_FS_BUS_WD = 39;
  localparam int FS_TO_DS_BUS_WD = 71;

  // A full response and an exception handoff can land in one cycle.
  localparam int ENQ_MAX = 5;

  typedef struct packed {
    logic        tlb_refill;
    logic        has_exc;
    logic [4:0]  exc_type;
    logic [31:0] pc;
  } pf_fs_t;

  typedef struct packed {
    logic        tlb_refill;
    logic        has_exc;
    logic [4:0]  exc_type;
    logic [31:0] pc;
    logic [31:0] inst;
  } fs_ds_t;

endpackage

// File: rtl/if_stage_if.sv
// Handshake bundle around the fetch stage: pre-IF handoff,
// inst-cache response, flush and decode hand-off.
import if_stage_pkg::*;

interface if_stage_if;

  logic                       to_fs_valid;
  logic [PF_TO_FS_BUS_WD-1:0] preif_to_fs_bus;
  logic                       fs_allowin;
  logic [5:0]                 inst_offset;
  logic                       inst_cache_data_ok;
  logic [127:0]               inst_cache_rdata;
  logic [2:0]                 inst_cache_rnum;
  logic                       pfs_reflush;
  logic                       ds_allowin;
  logic                       to_ds_valid;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;

  modport master (
    output to_fs_valid,
    output preif_to_fs_bus,
    output inst_cache_data_ok,
    output inst_cache_rdata,
    output inst_cache_rnum,
    output pfs_reflush,
    output ds_allowin,
    input  fs_allowin,
    input  inst_offset,
    input  to_ds_valid,
    input  fs_to_ds_bus
  );

  modport slave (
    input  to_fs_valid,
    input  preif_to_fs_bus,
    input  inst_cache_data_ok,
    input  inst_cache_rdata,
    input  inst_cache_rnum,
    input  pfs_reflush,
    input  ds_allowin,
    output fs_allowin,
    output inst_offset,
    output to_ds_valid,
    output fs_to_ds_bus
  );

endinterface

// File: rtl/if_stage_fs_inst_queue.sv
// Circular instruction queue: several writes and one read per cycle;
// flush empties it before that cycle's writes land.
import if_stage_pkg::*;

module fs_inst_queue #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [2:0]               wr_num,
  input  fs_ds_t [ENQ_MAX-1:0]     wr_data,
  input  logic                     rd_en,
  output fs_ds_t                   rd_data,
  output logic [AW:0]              count
);

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW-1:0] tail_b;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   cnt_b;
  logic          rd;
  fs_ds_t        mem_q [DEPTH];
  fs_ds_t        mem_d [DEPTH];

  always_comb begin
    mem_d  = mem_q;
    rd     = rd_en & ~flush;
    tail_b = flush ? '0 : tail_q;
    cnt_b  = flush ? '0 : cnt_q;
    head_d = flush ? '0 : head_q + AW'(rd);
    for (int i = 0; i < ENQ_MAX; i++) begin
      if (3'(i) < wr_num)
        mem_d[tail_b + AW'(i)] = wr_data[i];
    end
    tail_d = tail_b + AW'(wr_num);
    cnt_d  = cnt_b + (AW+1)'(wr_num)
           - (AW+1)'(rd);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= mem_d[i];
    end
  end

  assign rd_data = mem_q[head_q];
  assign count   = cnt_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding inst-cache request, 1-4 insts
// queued per response. IF_QUEUE_BYPASS_EN presents entry 0 on data_ok.
import if_stage_pkg::*;

module if_stage #(
  parameter int QUEUE_DEPTH = 8
) (
  input logic       clk,
  input logic       reset,
  if_stage_if.slave fs
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam logic [AW+1:0] SPACE_LIM =
    (AW+2)'(QUEUE_DEPTH - 4);

  pf_fs_t pf;
  fs_ds_t exc_ent;
  fs_ds_t [3:0] ent;
  fs_ds_t [ENQ_MAX-1:0] wr_data;
  fs_ds_t rd_data;
  fs_ds_t head;

  logic        pending_q, pending_d;
  logic        cancel_q, cancel_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [5:0]  offset_q, offset_d;

  logic [AW:0]   count;
  logic [AW+1:0] need;
  logic [2:0]    rnum_c;
  logic [2:0]    skip;
  logic [2:0]    wr_num;
  logic [5:0]    resp_off;
  logic data_ok, reflush, resp, space, allowin;
  logic accept, req_acc, exc_acc;
  logic byp, byp_take, head_valid, rd_en;

  assign pf       = fs.preif_to_fs_bus;
  assign data_ok  = fs.inst_cache_data_ok;
  assign reflush  = fs.pfs_reflush;
  assign rnum_c   = (fs.inst_cache_rnum > 3'd4)
                  ? 3'd4 : fs.inst_cache_rnum;
  assign resp_off = {1'b0, fs.inst_cache_rnum, 2'b00};
  assign resp     = data_ok & ~cancel_q & ~reflush;

  // Space is judged before any same-cycle dequeue.
  assign need    = {1'b0, count}
                 + (AW+2)'(data_ok ? rnum_c : 3'd0);
  assign space   = reflush | (need <= SPACE_LIM);
  assign allowin = ~reset & (~pending_q | data_ok)
                 & space;

  assign accept  = fs.to_fs_valid & allowin;
  assign req_acc = accept & ~pf.has_exc;
  assign exc_acc = accept & pf.has_exc;

`ifdef IF_QUEUE_BYPASS_EN
  assign byp = resp & (count == '0);
`else
  assign byp = 1'b0;
`endif

  assign head_valid = ((count != '0) | byp) & ~reflush;
  assign head       = byp ? ent[0] : rd_data;
  assign byp_take   = byp & fs.ds_allowin;
  assign rd_en      = head_valid & fs.ds_allowin
                    & (count != '0);
  assign skip       = {2'b00, byp_take};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ent[i]      = '0;
      ent[i].pc   = req_pc_q + 32'(4 * i);
      ent[i].inst = fs.inst_cache_rdata[32*i +: 32];
    end
    exc_ent            = '0;
    exc_ent.tlb_refill = pf.tlb_refill;
    exc_ent.has_exc    = pf.has_exc;
    exc_ent.exc_type   = pf.exc_type;
    exc_ent.pc         = pf.pc;
  end

  // Response entries first (older), then the exception entry.
  always_comb begin
    wr_data = '0;
    wr_num  = 3'd0;
    if (resp) begin
      for (int i = 0; i < 4; i++) begin
        if (byp_take) begin
          if (i < 3) wr_data[i] = ent[i+1];
        end else begin
          wr_data[i] = ent[i];
        end
      end
      wr_num = rnum_c - skip;
    end
    if (exc_acc) begin
      wr_data[wr_num] = exc_ent;
      wr_num          = wr_num + 3'd1;
    end
  end

  always_comb begin
    pending_d = pending_q;
    cancel_d  = cancel_q;
    req_pc_d  = req_pc_q;
    offset_d  = offset_q;
    if (data_ok) begin
      pending_d = 1'b0;
      cancel_d  = 1'b0;
      offset_d  = resp_off;
    end else if (reflush & pending_q) begin
      cancel_d = 1'b1;
    end
    if (req_acc) begin
      pending_d = 1'b1;
      req_pc_d  = pf.pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= 1'b0;
      cancel_q  <= 1'b0;
      req_pc_q  <= '0;
      offset_q  <= 6'd4;
    end else begin
      pending_q <= pending_d;
      cancel_q  <= cancel_d;
      req_pc_q  <= req_pc_d;
      offset_q  <= offset_d;
    end
  end

  fs_inst_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .flush   (reflush),
    .wr_num  (wr_num),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .count   (count)
  );

  assign fs.fs_allowin   = allowin;
  assign fs.inst_offset  = data_ok ? resp_off : offset_q;
  assign fs.to_ds_valid  = head_valid;
  assign fs.fs_to_ds_bus = head_valid ? head : '0;

endmodule
